// File: rtl/mux_scan_sequencer.sv
// Scan controller for the 4-to-1 mux stage: steps the select bus through
// channels 0..3, samples y after a settle delay and reports a 4-bit word.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       y,
    output logic [1:0] s,
    output logic       busy,
    output logic       done,
    output logic [3:0] word,
    output logic [2:0] ones
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sh_q, sh_d;
    logic [1:0] s_q, s_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] word_q, word_d;
    logic [2:0] ones_q, ones_d;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        word_d  = word_q;
        ones_d  = ones_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = RELOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                if (ch_q != 2'd3) begin
                    for (int i = 0; i < 3; i++) begin
                        if (ch_q == 2'(i)) begin
                            sh_d[i] = y;
                        end
                    end
                    ch_d    = ch_q + 2'd1;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end else begin
                    // Last channel goes straight into the word so it is never seen partially.
                    word_d  = {y, sh_q};
                    ones_d  = 3'(y) + 3'(sh_q[0]) + 3'(sh_q[1]) + 3'(sh_q[2]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    state_d = SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        s_d    = 2'd0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            SETTLE, SAMPLE: begin
                s_d    = ch_d;
                busy_d = 1'b1;
            end
            DONE: begin
                s_d    = 2'd3;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= 4'd0;
            sh_q    <= 3'd0;
            s_q     <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            word_q  <= 4'd0;
            ones_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            word_q  <= word_d;
            ones_q  <= ones_d;
        end
    end

    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;
    assign word = word_q;
    assign ones = ones_q;

endmodule
